// File: rtl/uart_reading_rx.sv
// UART 8N1 receiver for sensor readings: synchronises rx_serial, samples mid-bit,
// holds the last good byte and strobes valid / framing_error for one clock each.
module uart_reading_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] reading,
    output logic       reading_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic          sync1_q, sync2_q;
    logic          rx_s;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    reading_q, reading_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign rx_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        reading_d = reading_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        reading_d = shift_q;
                        valid_d   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                // A break or stuck-low line must clear before a new start bit counts.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            reading_q <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx_serial;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            reading_q <= reading_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign reading       = reading_q;
    assign reading_valid = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != S_IDLE);

endmodule
